// File: rtl/div_pkg.sv
// div_pkg: shared constants and types for the 16-bit sequential divider.
//   DIV_W    - datapath width (16)
//   DIV_ITER - number of restoring iterations per divide (one quotient bit each)
//   CNT_W    - iteration counter width
//   div_state_t - controller states IDLE / RUN / DONE
package div_pkg;

    localparam int DIV_W    = 16;
    localparam int DIV_ITER = 16;
    localparam int CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Two's-complement negate at datapath width.
    function automatic logic [DIV_W-1:0] neg_w(input logic [DIV_W-1:0] v);
        return (~v) + DIV_W'(1);
    endfunction

endpackage

// File: rtl/div_sixteen_sub_seventeen.sv
// sub_seventeen: combinational 17-bit trial subtractor for the restoring divider.
//   i_a      [16:0] minuend (shifted partial remainder)
//   i_b      [16:0] subtrahend (zero-extended divisor)
//   o_diff   [16:0] i_a - i_b
//   o_borrow        1 when i_b > i_a (trial subtraction fails)
module sub_seventeen
    import div_pkg::*;
(
    input  logic [DIV_W:0] i_a,
    input  logic [DIV_W:0] i_b,
    output logic [DIV_W:0] o_diff,
    output logic           o_borrow
);

    assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/div_sixteen.sv
// div_sixteen: sequential 16-bit restoring divider, one quotient bit per clock.
// Optional build macro SIGNED_DIV_EN selects two's-complement operands
// (truncating division, remainder follows dividend sign, o flags 8000/FFFF).
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               request, sampled only in IDLE with dividend/divisor
//   dividend, divisor   16-bit operands
//   busy                high whenever not IDLE
//   done                one-cycle pulse; results valid from this cycle on
//   quotient, remainder registered results, held until the next completion
//   dz, o               divide-by-zero and signed-overflow flags
//
// state | meaning
// IDLE  | waiting for start; results hold
// RUN   | 16 trial-subtract iterations, counter 0..15
// DONE  | done pulse for one cycle, then IDLE
module div_sixteen
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             dz,
    output logic             o
);

    div_state_t       r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W:0]   r_rem;
    logic [DIV_W-1:0] r_q, r_dvsr;
    logic [DIV_W-1:0] r_quotient, r_remainder;
    logic             r_dz, r_o;
    logic             r_neg_q, r_neg_r, r_ovf;

    logic [DIV_W-1:0] w_a_mag, w_b_mag;
    logic             w_a_neg, w_b_neg, w_ovf;
    logic [DIV_W:0]   w_rshift, w_diff, w_rem_nx;
    logic             w_borrow, w_last;
    logic [DIV_W-1:0] w_q_nx, w_quo_fin, w_rem_fin;

    // Operand conditioning: the core always divides unsigned magnitudes.
    always_comb begin
        w_a_mag = dividend;
        w_b_mag = divisor;
        w_a_neg = 1'b0;
        w_b_neg = 1'b0;
        w_ovf   = 1'b0;
`ifdef SIGNED_DIV_EN
        w_a_neg = dividend[DIV_W-1];
        w_b_neg = divisor[DIV_W-1];
        w_a_mag = w_a_neg ? neg_w(dividend) : dividend;
        w_b_mag = w_b_neg ? neg_w(divisor)  : divisor;
        w_ovf   = (dividend == 16'h8000) && (divisor == 16'hFFFF);
`endif
    end

    assign w_rshift = {r_rem[DIV_W-1:0], r_q[DIV_W-1]};

    sub_seventeen u_sub (
        .i_a      (w_rshift),
        .i_b      ({1'b0, r_dvsr}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    assign w_rem_nx  = w_borrow ? w_rshift : w_diff;
    assign w_q_nx    = {r_q[DIV_W-2:0], ~w_borrow};
    assign w_last    = (r_cnt == CNT_W'(DIV_ITER - 1));
    // Sign fix-up on the final iteration edge keeps latency identical to unsigned.
    assign w_quo_fin = r_neg_q ? neg_w(w_q_nx) : w_q_nx;
    assign w_rem_fin = r_neg_r ? neg_w(w_rem_nx[DIV_W-1:0]) : w_rem_nx[DIV_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next_state = (divisor == '0) ? DONE : RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_dvsr      <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_ovf       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
            r_o         <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_q     <= w_a_mag;
                        r_dvsr  <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_ovf   <= w_ovf;
                        if (divisor == '0) begin
                            r_quotient  <= 16'hFFFF;
                            r_remainder <= dividend;
                            r_dz        <= 1'b1;
                            r_o         <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_quotient  <= w_quo_fin;
                        r_remainder <= w_rem_fin;
                        r_dz        <= 1'b0;
                        r_o         <= r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dz        = r_dz;
    assign o         = r_o;

endmodule

// File: tb/tb_div_sixteen.sv
module tb_div_sixteen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy, done, dz, o;
    logic [15:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_sixteen dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .o         (o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    task automatic model(input logic [15:0] n, input logic [15:0] d,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic edz, output logic eo);
        int a, b;
        eo = 1'b0;
        edz = 1'b0;
        if (d == 16'h0) begin
            q = 16'hFFFF; r = n; edz = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            a = int'($signed(n));
            b = int'($signed(d));
            if (n == 16'h8000 && d == 16'hFFFF) begin
                q = 16'h8000; r = 16'h0000; eo = 1'b1;
            end else begin
                q = 16'(a / b);
                r = 16'(a % b);
            end
`else
            a = int'(n);
            b = int'(d);
            q = 16'(a / b);
            r = 16'(a % b);
`endif
        end
    endtask

    // Issues one request at the current (IDLE) negedge and waits for done.
    // poke: re-assert start mid-RUN with different operands; it must be ignored.
    task automatic run_op(input string tag, input logic [15:0] n, input logic [15:0] d,
                          input bit poke);
        logic [15:0] eq, er, q0, r0;
        logic        edz, eo;
        bit          moved;
        int          k;
        model(n, d, eq, er, edz, eo);
        q0 = quotient;
        r0 = remainder;
        moved = 1'b0;
        dividend = n;
        divisor  = d;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        chk({tag, "_busy"}, busy, 1);
        while (!done && k < 40) begin
            if (quotient !== q0 || remainder !== r0) moved = 1'b1;
            if (poke && k == 5) begin
                dividend = 16'h0001;
                divisor  = 16'h0001;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, k, (d == 16'h0) ? 1 : 17);
        chk({tag, "_stable_in_run"}, moved, 0);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dz"}, dz, edz);
        chk({tag, "_o"}, o, eo);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [15:0] n, d, hq, hr;
        logic        hdz, ho;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_results", {quotient, remainder, dz, o}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op("u_1000_7", 16'h03E8, 16'h0007, 0);
        chk("u_1000_7_q_const", quotient, 16'h008E);
        chk("u_1000_7_r_const", remainder, 16'h0006);

        // Second request lands the first IDLE cycle; first one gets an ignored poke.
        dividend = 16'hFFFF; divisor = 16'h0001;
        run_op("u_ffff_1", 16'hFFFF, 16'h0001, 1);
        run_op("u_3_10", 16'h0003, 16'h000A, 0);
        chk("u_3_10_r_const", remainder, 16'h0003);

        run_op("dz_5_0", 16'h0005, 16'h0000, 0);

        // Reset mid-operation after 8 iterations.
        dividend = 16'h1234; divisor = 16'h0011; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy_before_reset", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_done", done, 0);
        chk("mid_reset_results", {quotient, remainder, dz, o}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("after_reset", 16'h1234, 16'h0011, 0);
        chk("after_reset_q_const", quotient, 16'h0112);
        chk("after_reset_r_const", remainder, 16'h0002);

`ifdef SIGNED_DIV_EN
        run_op("s_m7_2", 16'hFFF9, 16'h0002, 0);
        chk("s_m7_2_q_const", quotient, 16'hFFFD);
        chk("s_m7_2_r_const", remainder, 16'hFFFF);
        run_op("s_ovf", 16'h8000, 16'hFFFF, 0);
        chk("s_ovf_o_const", o, 1);
        run_op("s_m100_m7", 16'hFF9C, 16'hFFF9, 0);
        run_op("s_dz", 16'h8001, 16'h0000, 0);
`endif

        for (int i = 0; i < 30; i++) begin
            n = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       d = 16'h0000;
                1:       d = 16'($urandom_range(1, 15));
                default: d = 16'($urandom);
            endcase
            run_op("rand", n, d, (i % 7) == 3);
        end

        // Results must hold with done low over a long idle stretch.
        hq = quotient; hr = remainder; hdz = dz; ho = o;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold", {done, busy, dz, o, quotient, remainder},
                {1'b0, 1'b0, hdz, ho, hq, hr});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
